// File: rtl/seg7_pkg.sv
// Shared constants for the bus-mapped seven-segment display controller:
// register offsets, CTRL bit positions and the active-low glyph table.
package seg7_pkg;

  // Offsets are added to NUM_DIGITS/2, i.e. they follow the digit-pair registers.
  localparam int CTRL_OFS    = 0;
  localparam int DP_MASK_OFS = 1;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_LZS_BIT    = 1;

  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

  // Active-low segments g..a for nibble values 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic enable;
    logic lzs;
  } ctrl_t;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-low seven-segment decoder (g..a).
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg7_bus_display.sv
// Bus-mapped, time-multiplexed N-digit common-anode display controller.
// Optional anode dead-time at the start of every slot: define SEG7_GHOST_BLANK_EN.
module seg7_bus_display
  import seg7_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'hD0,
  parameter int         NUM_DIGITS   = 4,
  parameter int         REFRESH_DIV  = 100000,
  parameter int         BLANK_CYCLES = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BUS_WE,
  input  logic [7:0]            BUS_ADDR,
  input  logic [7:0]            BUS_DATA,
  output logic [NUM_DIGITS-1:0] SEG_SELECT_OUT,
  output logic [7:0]            HEX_OUT
);

  localparam int PAIRS = NUM_DIGITS / 2;
  localparam int PRE_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);

  if ((NUM_DIGITS % 2) != 0 || NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("seg7_bus_display: NUM_DIGITS must be even and within 2..8");
  end
  if (REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_timing
    $error("seg7_bus_display: need REFRESH_DIV >= 2 and BLANK_CYCLES < REFRESH_DIV");
  end

  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp_mask;
  ctrl_t                   r_ctrl;
  logic [PRE_W-1:0]        r_pre;
  logic [IDX_W-1:0]        r_index;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic [7:0]              r_hex;

  logic [7:0]            w_offset;
  logic [3:0]            w_nibble;
  logic                  w_dp;
  logic                  w_blank;
  logic                  w_zero_tail;
  logic [NUM_DIGITS-1:0] w_suppress;
  logic [6:0]            w_seg;
  logic                  w_ghost;
  logic [NUM_DIGITS-1:0] w_sel_next;
  logic [7:0]            w_hex_next;

  assign w_offset = BUS_ADDR - BASE_ADDR;

`ifdef SEG7_GHOST_BLANK_EN
  assign w_ghost = (r_pre < PRE_W'(BLANK_CYCLES));
`else
  assign w_ghost = 1'b0;
`endif

  // A digit is a suppressed leading zero when it and everything above it is a dark zero.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_zero_tail = 1'b1;
    w_suppress  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_zero_tail   = w_zero_tail & (r_digits[4*i +: 4] == 4'h0) & ~r_dp_mask[i];
      w_suppress[i] = w_zero_tail;
    end
  end

  always_comb begin
    w_nibble = 4'h0;
    w_dp     = 1'b0;
    w_blank  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_index == IDX_W'(i)) begin
        w_nibble = r_digits[4*i +: 4];
        w_dp     = r_dp_mask[i];
        w_blank  = w_suppress[i];
      end
    end
  end

  seg7_hex_decoder u_decoder (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_comb begin
    w_sel_next = '1;
    w_hex_next = SEG_ALL_OFF;
    if (r_ctrl.enable && !w_ghost) begin
      w_sel_next = ~(NUM_DIGITS'(1) << r_index);
      if (!(r_ctrl.lzs && w_blank)) begin
        w_hex_next = {~w_dp, w_seg};
      end
    end
  end

  // Reset wins over a concurrent bus write; the digit registers are cleared too.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_digits  <= '0;
      r_dp_mask <= '0;
      r_ctrl    <= '{enable: 1'b1, lzs: 1'b0};
      r_pre     <= '0;
      r_index   <= '0;
      r_sel     <= '1;
      r_hex     <= SEG_ALL_OFF;
    end else begin
      if (r_pre == PRE_MAX) begin
        r_pre   <= '0;
        r_index <= (r_index == IDX_MAX) ? '0 : r_index + 1'b1;
      end else begin
        r_pre <= r_pre + 1'b1;
      end

      if (BUS_WE) begin
        for (int k = 0; k < PAIRS; k++) begin
          if (w_offset == 8'(k)) r_digits[8*k +: 8] <= BUS_DATA;
        end
        if (w_offset == 8'(PAIRS + CTRL_OFS)) begin
          r_ctrl <= '{enable: BUS_DATA[CTRL_ENABLE_BIT], lzs: BUS_DATA[CTRL_LZS_BIT]};
        end
        if (w_offset == 8'(PAIRS + DP_MASK_OFS)) begin
          r_dp_mask <= BUS_DATA[NUM_DIGITS-1:0];
        end
      end

      r_sel <= w_sel_next;
      r_hex <= w_hex_next;
    end
  end

  assign SEG_SELECT_OUT = r_sel;
  assign HEX_OUT        = r_hex;

endmodule
